// File: rtl/dense_l2.sv
// Fully-connected readout: streams the 32x32 layer-1 map once per output neuron,
// multiply-accumulates against ROM weights plus bias, then writes ReLU'd Q4.16 results.
module dense_l2 #(
  parameter int         NUM_OUT  = 10,
  parameter int         FEAT_LEN = 1024,
  parameter logic [2:0] L1_SEL   = 3'd3,
  parameter logic [2:0] OUT_SEL  = 3'd5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        crd,
  output logic [11:0] caddr_rd,
  input  logic [19:0] cdata_rd,
  output logic        cwr,
  output logic [11:0] caddr_wr,
  output logic [19:0] cdata_wr,
  output logic [2:0]  csel,
  output logic [13:0] waddr,
  input  logic [19:0] wdata,
  output logic [3:0]  baddr,
  input  logic [19:0] bdata
);

  localparam int I_W = (FEAT_LEN > 1) ? $clog2(FEAT_LEN) : 1;

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_MAC, S_WRITE, S_NEXT} state_t;

  state_t               state, state_next;
  logic [I_W-1:0]       feat_idx;
  logic [3:0]           n;
  logic signed [49:0]   acc;
  logic signed [39:0]   prod;
  logic signed [49:0]   acc_base, acc_sum;
  logic [20:0]          rounded;
  logic [19:0]          relu_out;
  logic                 last_feat, last_neuron;

  assign last_feat   = (feat_idx == I_W'(FEAT_LEN - 1));
  assign last_neuron = (n == 4'(NUM_OUT - 1));

  // Q4.16 x Q4.16 -> Q8.32; the bias enters aligned to the same binary point.
  assign prod     = $signed(cdata_rd) * $signed(wdata);
  assign acc_base = (feat_idx == '0) ? {{14{bdata[19]}}, bdata, 16'd0} : acc;
  assign acc_sum  = acc_base + {{10{prod[39]}}, prod};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    relu_out = '0;
    rounded  = {1'b0, acc[35:16]} + 21'(acc[15]);
    if (acc[49])
      relu_out = '0;
    else if ((|acc[48:35]) || (rounded > 21'h7FFFF))
      relu_out = 20'h7FFFF;
    else
      relu_out = rounded[19:0];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (start) state_next = S_INIT;
      S_INIT:  state_next = S_MAC;
      S_MAC:   if (last_feat) state_next = S_WRITE;
      S_WRITE: state_next = S_NEXT;
      S_NEXT:  state_next = last_neuron ? S_IDLE : S_INIT;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every register sees
  // pre-edge values; the accumulator is a plain register and is cleared on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      crd      <= 1'b0;
      cwr      <= 1'b0;
      csel     <= '0;
      caddr_rd <= '0;
      caddr_wr <= '0;
      cdata_wr <= '0;
      waddr    <= '0;
      baddr    <= '0;
      feat_idx <= '0;
      n        <= '0;
      acc      <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            n    <= '0;
          end
        end
        S_INIT: begin
          crd      <= 1'b1;
          csel     <= L1_SEL;
          caddr_rd <= '0;
          waddr    <= 14'(int'(n) * FEAT_LEN);
          baddr    <= n;
          feat_idx <= '0;
        end
        S_MAC: begin
          acc <= acc_sum;
          if (!last_feat) begin
            caddr_rd <= caddr_rd + 12'd1;
            waddr    <= waddr + 14'd1;
            feat_idx <= feat_idx + 1'b1;
          end else begin
            crd <= 1'b0;
          end
        end
        S_WRITE: begin
          cwr      <= 1'b1;
          csel     <= OUT_SEL;
          caddr_wr <= 12'(n);
          cdata_wr <= relu_out;
        end
        S_NEXT: begin
          cwr <= 1'b0;
          n   <= n + 4'd1;
          if (last_neuron) begin
            // Leave every output at its idle value once the run completes.
            busy     <= 1'b0;
            done     <= 1'b1;
            csel     <= '0;
            caddr_rd <= '0;
            caddr_wr <= '0;
            cdata_wr <= '0;
            waddr    <= '0;
            baddr    <= '0;
            n        <= '0;
            acc      <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
